// File: rtl/mem_loader.sv
// Byte-stream loader: assembles big-endian 16-bit words from a framed
// byte stream and writes them to consecutive dsram addresses.
module mem_loader #(
    parameter int WIDTH      = 13,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  we,
    output logic [WIDTH-1:0]      mem_din_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        A_HI,
        A_LO,
        C_HI,
        C_LO,
        D_HI,
        D_LO,
        FIN
    } state_t;

    state_t           state;
    logic [7:0]       hi;
    logic [WIDTH-1:0] addr;
    logic [15:0]      cnt;
    logic [15:0]      word;

    assign word = {hi, in_data};

    // Status flags are pure decodes of the state register.
    // A last-word write leaves we high in the first FIN cycle; done is
    // held back until that write pulse has gone, so done follows we.
    assign in_ready = (state != IDLE) && (state != FIN);
    assign busy     = (state != IDLE);
    assign done     = (state == FIN) && !we;

    // Frame parser, word counter and registered write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            hi           <= 8'd0;
            addr         <= '0;
            cnt          <= 16'd0;
            we           <= 1'b0;
            mem_din_addr <= '0;
            mem_din      <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= A_HI;
                end
                A_HI: begin
                    if (in_valid) begin
                        hi    <= in_data;
                        state <= A_LO;
                    end
                end
                A_LO: begin
                    if (in_valid) begin
                        addr  <= word[WIDTH-1:0];
                        state <= C_HI;
                    end
                end
                C_HI: begin
                    if (in_valid) begin
                        hi    <= in_data;
                        state <= C_LO;
                    end
                end
                C_LO: begin
                    if (in_valid) begin
                        cnt   <= word;
                        state <= (word == 16'd0) ? FIN : D_HI;
                    end
                end
                D_HI: begin
                    if (in_valid) begin
                        hi    <= in_data;
                        state <= D_LO;
                    end
                end
                D_LO: begin
                    if (in_valid) begin
                        we           <= 1'b1;
                        mem_din      <= DATA_WIDTH'(word);
                        mem_din_addr <= addr;
                        addr         <= addr + WIDTH'(1);
                        cnt          <= cnt - 16'd1;
                        state        <= (cnt == 16'd1) ? FIN : D_HI;
                    end
                end
                FIN: begin
                    if (!we) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: scoreboard of expected
// (address, data) writes, popped whenever the loader pulses we.
module tb_mem_loader;

    localparam int WIDTH = 13;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [WIDTH-1:0]  mem_din_addr;
    logic [15:0]       mem_din;
    logic              busy;
    logic              done;

    int total;
    int bad;
    int nwr;

    logic [WIDTH+15:0] exp_q[$];
    logic [15:0]       wbuf[8];
    int                wn;

    mem_loader #(.WIDTH(WIDTH), .DATA_WIDTH(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .we           (we),
        .mem_din_addr (mem_din_addr),
        .mem_din      (mem_din),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every we pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            nwr++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got=%h:%h want=none",
                         mem_din_addr, mem_din);
            end else begin
                logic [WIDTH+15:0] e;
                e = exp_q.pop_front();
                if ({mem_din_addr, mem_din} !== e) begin
                    bad++;
                    $display("FAIL write got=%h:%h want=%h:%h",
                             mem_din_addr, mem_din,
                             e[WIDTH+15:16], e[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input logic st);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = st;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=ready0 want=ready1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // mode bit0: start coincides with a valid byte in IDLE
    // mode bit1: extra start pulse in the middle of the frame
    task automatic load(input logic [15:0] a, input int mode,
                        input int maxgap);
        logic [7:0]       bq[$];
        logic [WIDTH-1:0] ea;
        logic [15:0]      c;
        int               w0;
        int               g;
        c = 16'(wn);
        bq.push_back(a[15:8]);
        bq.push_back(a[7:0]);
        bq.push_back(c[15:8]);
        bq.push_back(c[7:0]);
        ea = a[WIDTH-1:0];
        for (int i = 0; i < wn; i++) begin
            bq.push_back(wbuf[i][15:8]);
            bq.push_back(wbuf[i][7:0]);
            exp_q.push_back({ea, wbuf[i]});
            ea = ea + WIDTH'(1);
        end
        w0 = nwr;
        start = 1'b1;
        if (mode[0]) begin
            in_valid = 1'b1;
            in_data  = bq[0];
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL idle_ready got=%b want=0", in_ready);
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            send_byte(bq[i], g, mode[1] && (i == 2));
        end
        total++;
        if (wn == 0) begin
            if ({we, done} !== 2'b01) begin
                bad++;
                $display("FAIL zero_done got=we%b,done%b want=we0,done1",
                         we, done);
            end
        end else begin
            if ({we, done} !== 2'b10) begin
                bad++;
                $display("FAIL last_we got=we%b,done%b want=we1,done0",
                         we, done);
            end
            @(negedge clk);
            total++;
            if ({we, done} !== 2'b01) begin
                bad++;
                $display("FAIL done_after_we got=we%b,done%b want=we0,done1",
                         we, done);
            end
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after got=busy%b,done%b want=busy0,done0",
                     busy, done);
        end
        total++;
        if (nwr - w0 != wn) begin
            bad++;
            $display("FAIL write_count got=%0d want=%0d", nwr - w0, wn);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending got=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({busy, in_ready, we, done, mem_din_addr, mem_din} !== '0) begin
            bad++;
            $display("FAIL reset got=%b%b%b%b:%h:%h want=all0",
                     busy, in_ready, we, done, mem_din_addr, mem_din);
        end
    endtask

    task automatic test_reset_mid_frame();
        wn = 1;
        wbuf[0] = 16'h1111;
        exp_q.push_back({WIDTH'(13'h0007), 16'h1111});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h07, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total++;
        if ({busy, in_ready, we, done, mem_din_addr, mem_din} !== '0) begin
            bad++;
            $display("FAIL mid_reset got=%b%b%b%b:%h:%h want=all0",
                     busy, in_ready, we, done, mem_din_addr, mem_din);
        end
        exp_q.delete();
        wn = 1;
        wbuf[0] = 16'hBEEF;
        load(16'h0005, 0, 0);
    endtask

    task automatic test_basic();
        wn = 3;
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'h5678;
        wbuf[2] = 16'h9ABC;
        load(16'h0010, 0, 0);
    endtask

    task automatic test_zero_count();
        wn = 0;
        load(16'h0100, 0, 0);
    endtask

    task automatic test_wrap();
        wn = 2;
        wbuf[0] = 16'h0001;
        wbuf[1] = 16'h0002;
        load(16'hFFFF, 0, 0);
    endtask

    task automatic test_stalls();
        wn = 4;
        wbuf[0] = 16'hA5A5;
        wbuf[1] = 16'h0F0F;
        wbuf[2] = 16'hC3C3;
        wbuf[3] = 16'h7E81;
        load(16'h0333, 0, 3);
    endtask

    task automatic test_ignored_start();
        wn = 2;
        wbuf[0] = 16'hDEAD;
        wbuf[1] = 16'hCAFE;
        load(16'h0040, 3, 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nwr   = 0;
        test_reset();
        test_reset_mid_frame();
        test_basic();
        test_zero_count();
        test_wrap();
        test_stalls();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
